int2ieee_stream: RTL and testbench
==================================

INT2IEEE_STREAM -- requirements
Module: int2ieee_stream

Interface
REQ-001 SHALL have parameter DataWidth, default 32, meaning integer and IEEE word width; legal values 32 (binary32) and 64 (binary64).
REQ-002 SHALL have parameter Latency, default 1, meaning number of register stages, legal 0..4.
REQ-003 SHALL have dependent parameter data_t = logic [DataWidth-1:0], never overridden.
REQ-004 SHALL have port clk_i input 1: single clock; all state on its rising edge.
REQ-005 SHALL have port rst_ni input 1: reset, asynchronous, active-low.
REQ-006 SHALL have port valid_i input 1: input word valid.
REQ-007 SHALL have port ready_o output 1: block accepts input this cycle.
REQ-008 SHALL have port int_i input DataWidth: integer operand.
REQ-009 SHALL have port signed_i input 1: 1 = int_i is two's complement, 0 = unsigned.
REQ-010 SHALL have port valid_o output 1: result valid.
REQ-011 SHALL have port ready_i input 1: downstream accepts result.
REQ-012 SHALL have port ieee_o output DataWidth: IEEE 754 result.
REQ-013 SHALL have port inexact_o output 1: result was rounded.

Function
REQ-014 SHALL transfer input on valid_i && ready_o and output on valid_o && ready_i.
REQ-015 Zero input SHALL give +0 (all bits 0), inexact 0.
REQ-016 Signed negative input SHALL set sign bit 1 with magnitude = two's-complement negation, computed in DataWidth+1 bits so the most negative value converts exactly.
REQ-017 Exponent SHALL be bias + p, p = leading-one position of magnitude; bias 127 (W=32) / 1023 (W=64); mantissa M = 23 / 52 bits below the leading one.
REQ-018 When p > M, result SHALL be rounded to nearest, ties-to-even, using guard bit and sticky OR of remaining discarded bits.
REQ-019 Rounding carry out of mantissa SHALL increment exponent and clear mantissa.
REQ-020 inexact_o SHALL be 1 exactly when any discarded bit is 1; overflow cannot occur and SHALL NOT be flagged.
REQ-021 Latency=0: purely combinational; valid_o = valid_i, ready_o = ready_i.
REQ-022 Latency=N>0: N-stage elastic pipeline, each stage holding valid bit plus data; result appears N cycles after acceptance when not stalled.
REQ-023 A stage SHALL advance when the next stage is empty or advancing; last stage advances on ready_i; ready_o = stage 0 empty or advancing.
REQ-024 Throughput SHALL be one result per cycle with ready_i held 1.
REQ-025 While valid_o && !ready_i, ieee_o and inexact_o SHALL remain stable.
REQ-026 Results SHALL leave in acceptance order, none dropped or duplicated; simultaneous accept and emit in one cycle SHALL both occur.
REQ-027 ready_o SHALL depend combinationally only on ready_i and stage valid bits, never on valid_i.

Reset
REQ-028 On rst_ni low, all stage valid bits and data registers SHALL clear asynchronously: valid_o 0, ieee_o 0, inexact_o 0.
REQ-029 Reset mid-operation SHALL discard all in-flight items; first post-reset result SHALL be the first input accepted after release.
REQ-030 ready_o SHALL be 1 during and after reset when Latency>0.

Verification
REQ-031 W=32: int 1 signed -> 0x3F800000; -1 signed -> 0xBF800000; 0 -> 0x00000000; all inexact 0.
REQ-032 W=32: 0x80000000 signed -> 0xCF000000; unsigned -> 0x4F000000; inexact 0.
REQ-033 W=32 rounding: 0x01000001 -> 0x4B800000 inexact 1; 0x01000003 -> 0x4B800002 inexact 1; 0xFFFFFFFF unsigned -> 0x4F800000 inexact 1.
REQ-034 W=64: 0x8000000000000000 signed -> 0xC3E0000000000000; 0x0020000000000001 -> 0x4340000000000000 inexact 1.
REQ-035 Latency=2: send 4 words back-to-back with ready_i low 5 cycles -> ready_o falls after 2 accepts, outputs held stable, all 4 emitted in order after release, no loss.
REQ-036 Latency=3: assert rst_ni low with 3 items in flight -> valid_o 0 immediately; next accepted word is the first emitted.

Source files
------------

// File: rtl/int2ieee_stream.sv
// Integer to IEEE 754 (binary32 / binary64) converter with an elastic
// valid/ready pipeline of configurable depth. Conversion is combinational
// at the input; the pipeline stages carry the finished result and the
// inexact flag.
module int2ieee_stream #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Latency   = 1,
    parameter type         data_t    = logic [DataWidth-1:0]
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  valid_i,
    output logic  ready_o,
    input  data_t int_i,
    input  logic  signed_i,
    output logic  valid_o,
    input  logic  ready_i,
    output data_t ieee_o,
    output logic  inexact_o
);

    localparam int unsigned ExpWidth = (DataWidth == 64) ? 11 : 8;
    localparam int unsigned ManWidth = (DataWidth == 64) ? 52 : 23;
    localparam int unsigned Bias     = (DataWidth == 64) ? 1023 : 127;
    localparam int unsigned ShWidth  = $clog2(DataWidth);

    logic                 neg;
    logic [DataWidth:0]   mag_wide;
    data_t                mag;
    logic [ShWidth-1:0]   lead_pos;
    logic [ShWidth-1:0]   shamt;
    logic [DataWidth-2:0] frac;
    logic [ManWidth-1:0]  mant;
    logic [ExpWidth-1:0]  exp_field;
    logic                 guard;
    logic                 sticky;
    logic                 round_up;
    logic [DataWidth-2:0] body;
    data_t                conv_ieee;
    logic                 conv_inexact;

    // Convert the current input word: magnitude, normalise, round to nearest even.
    always_comb begin
        neg      = signed_i & int_i[DataWidth-1];
        // One extra bit so the most negative value negates to +2^(W-1) exactly.
        mag_wide = neg ? ((DataWidth + 1)'(0) - {int_i[DataWidth-1], int_i})
                       : {1'b0, int_i};
        mag      = mag_wide[DataWidth-1:0];
        lead_pos = '0;
        for (int i = 0; i < DataWidth; i++) begin
            if (mag[i]) begin
                lead_pos = ShWidth'(i);
            end
        end
        shamt     = ShWidth'(DataWidth - 1) - lead_pos;
        // Leading one shifted to bit W-1 and dropped; frac holds the bits below it.
        frac      = (DataWidth - 1)'(mag << shamt);
        mant      = frac[DataWidth-2 -: ManWidth];
        guard     = frac[DataWidth-2-ManWidth];
        sticky    = |frac[DataWidth-3-ManWidth:0];
        round_up  = guard & (sticky | mant[0]);
        exp_field = ExpWidth'(Bias) + ExpWidth'(lead_pos);
        // A carry out of the mantissa ripples into the exponent field.
        body      = {exp_field, mant} + (DataWidth - 1)'(round_up);
        if (mag_wide == '0) begin
            conv_ieee    = '0;
            conv_inexact = 1'b0;
        end else begin
            conv_ieee    = {neg, body};
            conv_inexact = guard | sticky;
        end
    end

    if (Latency == 0) begin : g_comb
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_ni;
        assign valid_o   = valid_i;
        assign ready_o   = ready_i;
        assign ieee_o    = conv_ieee;
        assign inexact_o = conv_inexact;
    end else begin : g_pipe
        logic [Latency-1:0] stage_valid;
        logic [DataWidth:0] stage_data [Latency];
        logic [Latency-1:0] advance;

        // A stage may load when it is empty or the stage after it is moving on.
        always_comb begin
            advance[Latency-1] = !stage_valid[Latency-1] || ready_i;
            for (int i = int'(Latency) - 2; i >= 0; i--) begin
                advance[i] = !stage_valid[i] || advance[i+1];
            end
        end

        for (genvar gi = 0; gi < Latency; gi++) begin : g_stage
            logic               valid_reg;
            logic [DataWidth:0] data_reg;
            logic               src_valid;
            logic [DataWidth:0] src_data;

            if (gi == 0) begin : g_head
                assign src_valid = valid_i;
                assign src_data  = {conv_inexact, conv_ieee};
            end else begin : g_link
                assign src_valid = stage_valid[gi-1];
                assign src_data  = stage_data[gi-1];
            end

            // Stage register: holds while stalled, clears asynchronously on reset.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                end else if (advance[gi]) begin
                    valid_reg <= src_valid;
                    data_reg  <= src_data;
                end
            end

            assign stage_valid[gi] = valid_reg;
            assign stage_data[gi]  = data_reg;
        end

        assign ready_o   = advance[0];
        assign valid_o   = stage_valid[Latency-1];
        assign inexact_o = stage_data[Latency-1][DataWidth];
        assign ieee_o    = stage_data[Latency-1][DataWidth-1:0];
    end

endmodule

// File: tb/tb_int2ieee_stream.sv
// Bench for int2ieee_stream: three instances (W32/L2, W64/L3, W32/L0) checked
// against an arithmetic reference model through per-instance scoreboards,
// plus literal vectors, stall, latency, throughput and reset scenarios.
module tb_int2ieee_stream;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [2:0]  in_valid, in_signed, out_ready;
    logic [2:0]  dut_ready, dut_valid, dut_inexact;
    logic [63:0] in_int [3];
    logic [31:0] ieee_a, ieee_c;
    logic [63:0] ieee_b;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [64:0] q0[$], q1[$], q2[$];
    logic [65:0] held [3];
    logic [2:0]  stalled;

    always #5 clk_i = ~clk_i;

    int2ieee_stream #(.DataWidth(32), .Latency(2)) u_a (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(in_valid[0]), .ready_o(dut_ready[0]),
        .int_i(in_int[0][31:0]), .signed_i(in_signed[0]), .valid_o(dut_valid[0]),
        .ready_i(out_ready[0]), .ieee_o(ieee_a), .inexact_o(dut_inexact[0]));

    int2ieee_stream #(.DataWidth(64), .Latency(3)) u_b (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(in_valid[1]), .ready_o(dut_ready[1]),
        .int_i(in_int[1]), .signed_i(in_signed[1]), .valid_o(dut_valid[1]),
        .ready_i(out_ready[1]), .ieee_o(ieee_b), .inexact_o(dut_inexact[1]));

    int2ieee_stream #(.DataWidth(32), .Latency(0)) u_c (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(in_valid[2]), .ready_o(dut_ready[2]),
        .int_i(in_int[2][31:0]), .signed_i(in_signed[2]), .valid_o(dut_valid[2]),
        .ready_i(out_ready[2]), .ieee_o(ieee_c), .inexact_o(dut_inexact[2]));

    function automatic int wid(int k);
        return (k == 1) ? 64 : 32;
    endfunction

    // Reference: exact integer arithmetic, round by comparing the remainder to half an ulp.
    function automatic logic [64:0] ref_conv(logic [63:0] x, logic sgn, int w);
        int m    = (w == 64) ? 52 : 23;
        int bias = (w == 64) ? 1023 : 127;
        logic [127:0] xv, mag, t, r, half;
        logic neg, inex;
        logic [63:0] bits;
        int p, sh;
        xv  = (w == 64) ? {64'd0, x} : {96'd0, x[31:0]};
        neg = sgn && xv[w-1];
        mag = neg ? ((128'd1 << w) - xv) : xv;
        if (mag == 128'd0) return 65'd0;
        p = 0;
        for (int i = 0; i < 128; i++) if (mag[i]) p = i;
        sh = p - m;
        inex = 1'b0;
        if (sh <= 0) begin
            t = mag << (-sh);
        end else begin
            t    = mag >> sh;
            r    = mag - (t << sh);
            half = 128'd1 << (sh - 1);
            if (r > half || (r == half && t[0])) t = t + 128'd1;
            inex = (r != 128'd0);
            if (t == (128'd1 << (m + 1))) begin
                t = t >> 1;
                p = p + 1;
            end
        end
        if (w == 64) bits = {neg, 11'(p + bias), t[51:0]};
        else         bits = {32'd0, neg, 8'(p + bias), t[22:0]};
        return {inex, bits};
    endfunction

    function automatic logic [64:0] dut_res(int k);
        case (k)
            0:       return {dut_inexact[0], 32'd0, ieee_a};
            1:       return {dut_inexact[1], ieee_b};
            default: return {dut_inexact[2], 32'd0, ieee_c};
        endcase
    endfunction

    task automatic chk(string name, logic [65:0] act, logic [65:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic sb_push(int k, logic [64:0] v);
        case (k)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    function automatic int sb_size(int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic sb_pop(int k, output logic [64:0] v);
        case (k)
            0:       v = q0.pop_front();
            1:       v = q1.pop_front();
            default: v = q2.pop_front();
        endcase
    endtask

    // Compare process: scoreboard push on accept, pop/compare on emit, stall stability.
    always @(negedge clk_i) begin
        logic [64:0] act_v, exp_v;
        if (!rst_ni) begin
            q0.delete(); q1.delete(); q2.delete();
            stalled = '0;
        end else begin
            chk("l0_handshake", {64'd0, dut_valid[2], dut_ready[2]},
                {64'd0, in_valid[2], out_ready[2]});
            for (int k = 0; k < 3; k++) begin
                act_v = dut_res(k);
                if (in_valid[k] && dut_ready[k])
                    sb_push(k, ref_conv(in_int[k], in_signed[k], wid(k)));
                if (stalled[k])
                    chk($sformatf("hold%0d", k), {dut_valid[k], act_v}, held[k]);
                if (dut_valid[k] && out_ready[k]) begin
                    if (sb_size(k) == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL orphan%0d: got %h, required no output", k, act_v);
                    end else begin
                        sb_pop(k, exp_v);
                        $display("inst%0d out %h exp %h", k, act_v, exp_v);
                        chk($sformatf("result%0d", k), {1'b0, act_v}, {1'b0, exp_v});
                    end
                end
                stalled[k] = (k < 2) && dut_valid[k] && !out_ready[k];
                held[k]    = {dut_valid[k], act_v};
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Literal vector: pin the model, then drive the combinational instance.
    task automatic lit32(logic [31:0] x, logic s, logic [64:0] e);
        chk($sformatf("model32_%h", x), {1'b0, ref_conv({32'd0, x}, s, 32)}, {1'b0, e});
        in_int[2] = {32'd0, x}; in_signed[2] = s; in_valid[2] = 1'b1;
        #1;
        chk($sformatf("lit32_%h", x), {1'b0, dut_res(2)}, {1'b0, e});
        tick();
        in_valid[2] = 1'b0;
    endtask

    // Single word through an empty pipeline: returns cycles from presentation to valid_o.
    task automatic send_one(int k, logic [63:0] x, logic s, output int cyc, output logic [64:0] res);
        in_int[k] = x; in_signed[k] = s; in_valid[k] = 1'b1; out_ready[k] = 1'b1;
        cyc = 0;
        do begin
            tick();
            in_valid[k] = 1'b0;
            cyc++;
        end while (!dut_valid[k] && cyc < 20);
        res = dut_res(k);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] gen(int w);
        logic [63:0] r, v;
        int m = (w == 64) ? 52 : 23;
        int sh;
        r = {$urandom, $urandom};
        case ($urandom % 6)
            0: v = r;
            1: v = r >> ($urandom % 64);
            2: v = 64'd1 << ($urandom % w);
            3: v = (64'd1 << ($urandom % w)) - 64'd1;
            4: begin
                sh = 1 + int'($urandom % (w - 1 - m));
                v  = (((64'd1 << m) | (r & ((64'd1 << m) - 64'd1))) << sh) | (64'd1 << (sh - 1));
            end
            default: v = r & 64'hFF;
        endcase
        if (w == 32) v[63:32] = 32'd0;
        return v;
    endfunction

    initial begin
        int cyc, idx, acc, outs;
        logic [64:0] res;
        logic [63:0] words [4];

        rst_ni = 1'b0;
        in_valid = '0; in_signed = '0; out_ready = '1;
        for (int k = 0; k < 3; k++) in_int[k] = '0;
        #12;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_valid%0d", k), {65'd0, dut_valid[k]}, 66'd0);
            chk($sformatf("rst_data%0d", k), {1'b0, dut_res(k)}, 66'd0);
            chk($sformatf("rst_ready%0d", k), {65'd0, dut_ready[k]}, 66'd1);
        end
        tick();
        rst_ni = 1'b1;
        tick();

        // Literal vectors, binary32
        lit32(32'h00000001, 1'b1, {1'b0, 64'h3F800000});
        lit32(32'hFFFFFFFF, 1'b1, {1'b0, 64'hBF800000});
        lit32(32'h00000000, 1'b1, {1'b0, 64'h00000000});
        lit32(32'h80000000, 1'b1, {1'b0, 64'hCF000000});
        lit32(32'h80000000, 1'b0, {1'b0, 64'h4F000000});
        lit32(32'h01000001, 1'b0, {1'b1, 64'h4B800000});
        lit32(32'h01000003, 1'b0, {1'b1, 64'h4B800002});
        lit32(32'hFFFFFFFF, 1'b0, {1'b1, 64'h4F800000});

        // Literal vectors, binary64 through the 3-stage pipeline (latency too)
        chk("model64_min", {1'b0, ref_conv(64'h8000000000000000, 1'b1, 64)}, {2'b00, 64'hC3E0000000000000});
        send_one(1, 64'h8000000000000000, 1'b1, cyc, res);
        chk("lat64", 66'(cyc), 66'd3);
        chk("lit64_min", {1'b0, res}, {2'b00, 64'hC3E0000000000000});
        chk("model64_tie", {1'b0, ref_conv(64'h0020000000000001, 1'b0, 64)}, {2'b01, 64'h4340000000000000});
        send_one(1, 64'h0020000000000001, 1'b0, cyc, res);
        chk("lit64_tie", {1'b0, res}, {2'b01, 64'h4340000000000000});
        send_one(1, 64'h0000000000000001, 1'b1, cyc, res);
        chk("lit64_one", {1'b0, res}, {2'b00, 64'h3FF0000000000000});
        send_one(0, 64'h0000000000000005, 1'b0, cyc, res);
        chk("lat32", 66'(cyc), 66'd2);
        chk("lit32_five", {1'b0, res}, {2'b00, 64'h40A00000});

        // Back-to-back burst into the 2-stage pipeline with ready_i low for 5 cycles
        for (int i = 0; i < 4; i++) words[i] = gen(32);
        out_ready[0] = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid[0] = (idx < 4); in_int[0] = words[idx & 3]; in_signed[0] = 1'(c);
            @(negedge clk_i);
            if (in_valid[0] && dut_ready[0]) idx++;
            tick();
        end
        chk("stall_accepts", 66'(idx), 66'd2);
        chk("stall_ready", {65'd0, dut_ready[0]}, 66'd0);
        out_ready[0] = 1'b1;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            in_valid[0] = 1'b1; in_int[0] = words[idx & 3];
            @(negedge clk_i);
            if (dut_ready[0]) idx++;
            tick();
        end
        in_valid[0] = 1'b0;
        for (int c = 0; c < 10 && sb_size(0) != 0; c++) tick();
        chk("burst_drain", 66'(sb_size(0)), 66'd0);

        // Throughput: 12 consecutive accepts, 9 results in that window at latency 3
        acc = 0; outs = 0;
        for (int c = 0; c < 12; c++) begin
            in_valid[1] = 1'b1; in_int[1] = gen(64); in_signed[1] = 1'($urandom);
            @(negedge clk_i);
            if (dut_ready[1]) acc++;
            if (dut_valid[1]) outs++;
            tick();
        end
        in_valid[1] = 1'b0;
        chk("thru_accepts", 66'(acc), 66'd12);
        chk("thru_outputs", 66'(outs), 66'd9);
        repeat (6) tick();

        // Reset with three items in flight in the 3-stage pipeline
        out_ready[1] = 1'b0;
        acc = 0;
        for (int c = 0; c < 10 && acc < 3; c++) begin
            in_valid[1] = 1'b1; in_int[1] = gen(64);
            @(negedge clk_i);
            if (dut_ready[1]) acc++;
            tick();
        end
        in_valid[1] = 1'b0;
        chk("inflight_accepts", 66'(acc), 66'd3);
        rst_ni = 1'b0;
        #1;
        chk("midrst_valid", {65'd0, dut_valid[1]}, 66'd0);
        chk("midrst_data", {1'b0, dut_res(1)}, 66'd0);
        chk("midrst_ready", {64'd0, dut_ready[1:0]}, 66'd3);
        tick();
        rst_ni = 1'b1;
        send_one(1, 64'hFFFFFFFFFFFFFFFE, 1'b1, cyc, res);
        chk("postrst_first", {1'b0, res}, {2'b00, 64'hC000000000000000});
        chk("postrst_lat", 66'(cyc), 66'd3);

        // Randomised traffic on all three instances
        for (int c = 0; c < 2500; c++) begin
            for (int k = 0; k < 3; k++) begin
                in_valid[k]  = ($urandom % 4) != 0;
                out_ready[k] = ($urandom % 3) != 0;
                in_signed[k] = 1'($urandom);
                in_int[k]    = gen(wid(k));
            end
            tick();
        end
        in_valid = '0; out_ready = '1;
        repeat (10) tick();
        for (int k = 0; k < 3; k++) chk($sformatf("drain%0d", k), 66'(sb_size(k)), 66'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
